// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mm:ss stopwatch controller with run/pause/lap states
// Live sec/min counters, a lap snapshot, minute-carry pulse and a sticky hour overflow.
module stopwatch_ctrl (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_clr,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [1:0] state,
  output logic       co_min,
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [5:0] snap_sec_q, snap_sec_d;
  logic [5:0] snap_min_q, snap_min_d;
  logic       co_min_q, co_min_d;
  logic       ovf_q, ovf_d;
  logic       count_en;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      snap_sec_q <= 6'd0;
      snap_min_q <= 6'd0;
      co_min_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      snap_sec_q <= snap_sec_d;
      snap_min_q <= snap_min_d;
      co_min_q   <= co_min_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    min_d      = min_q;
    snap_sec_d = snap_sec_q;
    snap_min_d = snap_min_q;
    ovf_d      = ovf_q;
    co_min_d   = 1'b0;

    // The pre-edge state decides counting, so leaving RUN/LAP still counts this edge.
    count_en = (state_q == S_RUN) || (state_q == S_LAP);
    if (count_en) begin
      if (sec_q == 6'd59) begin
        sec_d    = 6'd0;
        co_min_d = 1'b1;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          ovf_d = 1'b1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (start_stop)   state_d = S_PAUSE;
        else if (lap_clr) state_d = S_LAP;
      end
      S_LAP: begin
        if (start_stop)   state_d = S_PAUSE;
        else if (lap_clr) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (start_stop) begin
          state_d = S_RUN;
        end else if (lap_clr) begin
          state_d = S_IDLE;
          sec_d   = 6'd0;
          min_d   = 6'd0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Snapshot captures the post-edge live value on entry to LAP.
    if ((state_q != S_LAP) && (state_d == S_LAP)) begin
      snap_sec_d = sec_d;
      snap_min_d = min_d;
    end
  end

  always_comb begin
    state  = state_q;
    co_min = co_min_q;
    ovf    = ovf_q;
    if (state_q == S_LAP) begin
      disp_sec = snap_sec_q;
      disp_min = snap_min_q;
    end else begin
      disp_sec = sec_q;
      disp_min = min_q;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
// Reference model keeps elapsed time as a single seconds count.
module tb_stopwatch_ctrl;

  localparam int IDLE  = 0;
  localparam int RUN   = 1;
  localparam int PAUSE = 2;
  localparam int LAP   = 3;

  logic       clk_1;
  logic       rst;
  logic       start_stop;
  logic       lap_clr;
  logic [5:0] disp_sec;
  logic [5:0] disp_min;
  logic [1:0] state;
  logic       co_min;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  int m_t, m_st, m_snap, m_ovf, m_co;

  stopwatch_ctrl dut (
    .clk_1      (clk_1),
    .rst        (rst),
    .start_stop (start_stop),
    .lap_clr    (lap_clr),
    .disp_sec   (disp_sec),
    .disp_min   (disp_min),
    .state      (state),
    .co_min     (co_min),
    .ovf        (ovf)
  );

  initial begin
    clk_1 = 1'b0;
    forever #5 clk_1 = ~clk_1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_t = 0; m_st = IDLE; m_snap = 0; m_ovf = 0; m_co = 0;
  endfunction

  function automatic void model_edge(input bit ss, input bit lc);
    m_co = 0;
    if (m_st == RUN || m_st == LAP) begin
      m_t = m_t + 1;
      if (m_t % 60 == 0) m_co = 1;
      if (m_t == 3600) begin
        m_t   = 0;
        m_ovf = 1;
      end
    end
    if (ss) begin
      m_st = (m_st == RUN || m_st == LAP) ? PAUSE : RUN;
    end else if (lc) begin
      if (m_st == RUN) begin
        m_st   = LAP;
        m_snap = m_t;
      end else if (m_st == LAP) begin
        m_st = RUN;
      end else if (m_st == PAUSE) begin
        m_st  = IDLE;
        m_t   = 0;
        m_ovf = 0;
      end
    end
  endfunction

  task automatic check_model();
    int shown;
    shown = (m_st == LAP) ? m_snap : m_t;
    check("disp_sec", disp_sec, shown % 60);
    check("disp_min", disp_min, shown / 60);
    check("state", state, m_st);
    check("co_min", co_min, m_co);
    check("ovf", ovf, m_ovf);
  endtask

  task automatic step(input bit ss, input bit lc);
    start_stop = ss;
    lap_clr    = lc;
    @(posedge clk_1);
    model_edge(ss, lc);
    #1;
    start_stop = 1'b0;
    lap_clr    = 1'b0;
    check_model();
  endtask

  task automatic run_to(input int target);
    for (int g = 0; g < 4000 && m_t != target; g++) step(1'b0, 1'b0);
    check("run_to", disp_min * 60 + disp_sec, target);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sec"}, disp_sec, 0);
    check({tag, "_min"}, disp_min, 0);
    check({tag, "_state"}, state, 0);
    check({tag, "_co"}, co_min, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    rst        = 1'b1;
    start_stop = 1'b0;
    lap_clr    = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk_1);
    @(posedge clk_1);
    #1;
    rst = 1'b0;

    // reset then start
    step(1'b1, 1'b0);
    check("start_state", state, 1);
    step(1'b0, 1'b0);
    check("start_sec1", disp_sec, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("start_sec5", disp_sec, 5);

    // lap then release
    run_to(10);
    step(1'b0, 1'b1);
    check("lap_state", state, 3);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check("lap_frozen", disp_sec, 11);
    end
    step(1'b0, 1'b1);
    check("lap_release", disp_sec, 17);
    check("lap_release_state", state, 1);

    // minute carry
    run_to(58);
    step(1'b0, 1'b0);
    check("carry_059", co_min, 0);
    step(1'b0, 1'b0);
    check("carry_co", co_min, 1);
    check("carry_min", disp_min, 1);
    check("carry_sec", disp_sec, 0);
    step(1'b0, 1'b0);
    check("carry_co_drop", co_min, 0);

    // pause and clear
    run_to(150);
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check("pause_hold", disp_min * 60 + disp_sec, 151);
    end
    step(1'b0, 1'b1);
    check("clear_state", state, 0);
    check("clear_disp", disp_min * 60 + disp_sec, 0);

    // overflow, then simultaneous commands
    step(1'b1, 1'b0);
    run_to(3599);
    step(1'b0, 1'b0);
    check("ovf_set", ovf, 1);
    check("ovf_co", co_min, 1);
    check("ovf_disp", disp_min * 60 + disp_sec, 0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check("ovf_pause_hold", ovf, 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("both_cmd_state", state, 2);
    step(1'b1, 1'b0);

    // asynchronous reset while in LAP at 3:07
    run_to(186);
    step(1'b0, 1'b1);
    check("lap307", disp_min * 60 + disp_sec, 187);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("idle_wait", state, 0);

    // randomized command pulses against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      step(r == 0 || r == 2, r == 1 || r == 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
